// File: rtl/busy_table_if.sv
// Rename/writeback lookup bundle for the physical-register busy table.
// The master side is rename plus writeback; the slave side is the table itself.
interface busy_table_if #(
   parameter int RWD   = 4,
   parameter int EWD   = 4,
   parameter int PRNUM = 128
);
   localparam int IDXW = $clog2(PRNUM);

   logic                           redir;
   logic [RWD-1:0]                 ren_valid;
   logic [RWD-1:0][1:0][15:0]      ren_prsa;
   logic [RWD-1:0][15:0]           ren_prda;
   logic [RWD-1:0]                 ren_wena;
   logic [RWD-1:0]                 ren_fire;
   logic [EWD-1:0]                 wb_valid;
   logic [EWD-1:0][15:0]           wb_prda;
   logic [RWD-1:0][1:0]            busy_resp;
   logic [IDXW:0]                  busy_count;

   modport master (
      output redir, ren_valid, ren_prsa, ren_prda, ren_wena, ren_fire,
             wb_valid, wb_prda,
      input  busy_resp, busy_count
   );

   modport slave (
      input  redir, ren_valid, ren_prsa, ren_prda, ren_wena, ren_fire,
             wb_valid, wb_prda,
      output busy_resp, busy_count
   );
endinterface

// File: rtl/busy_table.sv
// Physical-register busy table: zero-cycle lookup for rename with intra-bundle
// forwarding and same-cycle writeback bypass; set on accepted allocation.
module busy_table #(
   parameter int RWD   = 4,
   parameter int EWD   = 4,
   parameter int PRNUM = 128
) (
   input  logic       clk,
   input  logic       rst,
   busy_table_if.slave bt
);
   localparam int IDXW = $clog2(PRNUM);

   logic [PRNUM-1:0] busy_q, busy_d;
   logic [IDXW:0]    count_q, count_d;
   logic [PRNUM-1:0] set_vec, clr_vec;

   // Per-operand lookup; the older-slot scan takes priority over the table.
   genvar gi, gk;
   generate
      for (gi = 0; gi < RWD; gi++) begin : g_slot
         for (gk = 0; gk < 2; gk++) begin : g_opnd
            logic [IDXW-1:0] src_idx;
            logic            intra_hit;
            logic            wb_hit;

            assign src_idx = bt.ren_prsa[gi][gk][IDXW-1:0];

            always_comb begin
               intra_hit = 1'b0;
               for (int j = 0; j < gi; j++) begin
                  if (bt.ren_valid[j] && bt.ren_wena[j] &&
                      bt.ren_prda[j][IDXW-1:0] == src_idx)
                     intra_hit = 1'b1;
               end
            end

            always_comb begin
               wb_hit = 1'b0;
               for (int j = 0; j < EWD; j++) begin
                  if (bt.wb_valid[j] && bt.wb_prda[j][IDXW-1:0] == src_idx)
                     wb_hit = 1'b1;
               end
            end

            assign bt.busy_resp[gi][gk] = bt.ren_valid[gi] && (src_idx != '0) &&
                                          (intra_hit || (busy_q[src_idx] && !wb_hit));
         end
      end
   endgenerate

   always_comb begin
      set_vec = '0;
      for (int i = 0; i < RWD; i++) begin
         if (bt.ren_fire[i] && bt.ren_wena[i])
            set_vec[bt.ren_prda[i][IDXW-1:0]] = 1'b1;
      end
   end

   always_comb begin
      clr_vec = '0;
      for (int j = 0; j < EWD; j++) begin
         if (bt.wb_valid[j])
            clr_vec[bt.wb_prda[j][IDXW-1:0]] = 1'b1;
      end
   end

   // A new producer beats a same-cycle writeback; register 0 is pinned idle.
   always_comb begin
      if (bt.redir)
         busy_d = '0;
      else
         busy_d = set_vec | (busy_q & ~clr_vec);
      busy_d[0] = 1'b0;
   end

   always_comb begin
      count_d = '0;
      for (int e = 0; e < PRNUM; e++)
         count_d = count_d + (IDXW+1)'(busy_d[e]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q  <= '0;
         count_q <= '0;
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
      end
   end

   assign bt.busy_count = count_q;
endmodule

// File: doc/busy_table.md
# busy_table

Physical-register busy table between rename and the issue queue. Each rename slot gets a 2-bit busy vector, one bit per source operand; the issue queue latches it as its initial pending state. Entries are set when a renamed op with a destination is accepted into the issue queue. They are cleared when the execute stage broadcasts a result, and cleared wholesale on a pipeline redirect.

## Interface
- rwd, 4, rename width (slots per cycle)
- ewd, 4, execution/writeback width
- prnum, 128, number of physical registers (power of two); index = low $clog2(prnum) bits of a 16-bit address

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- redir  in  1  pipeline redirect (commit slot 0), flush
- ren_valid  in  rwd  slot i holds a valid renamed op; valid slots form a prefix
- ren_prsa  in  rwd×2×16  source physical register addresses
- ren_prda  in  rwd×16  destination physical register address
- ren_wena  in  rwd  slot i writes ren_prda
- ren_fire  in  rwd  slot i accepted by the issue queue this cycle (the issue queue's ready); a prefix of ren_valid
- wb_valid  in  ewd  writeback slot j valid
- wb_prda  in  ewd×16  writeback destination address
- busy_resp  out  rwd×2  busy bit per source operand, combinational
- busy_count  out  $clog2(prnum)+1  number of busy entries, registered

## Operation
- State: busy[prnum] bits. Physical register 0 is never busy: writes to index 0 are ignored and it always reads 0.
- busy_resp[i][k] is 1 when either of the following holds for s = ren_prsa[i][k]:
  - Intra-bundle: some older slot j < i has ren_valid[j] & ren_wena[j] and ren_prda[j] == s. This is checked first and overrides writeback.
  - Otherwise: busy[s] is set and no wb_valid[j] has wb_prda[j] == s. Same-cycle writeback bypass is required, because the issue queue does not apply wakeup to entries in their insertion cycle.
- busy_resp[i] = 0 when ren_valid[i] = 0, or when s indexes register 0.
- Next state, evaluated per entry in priority order:
  1. rst or redir: all entries cleared.
  2. Set if any slot i has ren_fire[i] & ren_wena[i] with ren_prda[i] indexing the entry. This beats a same-cycle clear, because the new producer wins.
  3. Clear if any wb_valid[j] has wb_prda[j] indexing the entry.
  4. Otherwise hold.
- Duplicate sets or clears to the same entry in one cycle are idempotent.
- busy_count is the popcount of the next state, registered in the same cycle as busy. It therefore always equals popcount(busy).
- A clear of a non-busy entry is legal and has no effect. Address bits above $clog2(prnum) are ignored.

## Timing
- Lookup is zero-cycle: busy_resp depends combinationally on the current state, ren_* and wb_*.
- An allocation in cycle t is visible in busy state from cycle t+1. Within cycle t it is visible only through the intra-bundle path.
- A writeback in cycle t is visible through busy_resp in cycle t and in state from t+1.
- Redirect in cycle t: busy_resp in cycle t is computed normally; the issue queue discards it. All entries are 0 and busy_count is 0 at t+1. Allocations in cycle t are dropped.
- Reset: all entries 0 and busy_count = 0 after the first clock edge with rst = 1. rst overrides everything, including mid-bundle allocations.

## Test plan
- Reset, then rename slot0 with prsa = {5, 6} and no writes → busy_resp[0] = 00, busy_count = 0.
- Fire slot0 with prda = 10 in cycle 1. In cycle 2, slot1 reads prsa[0] = 10 → busy_resp = 01 and busy_count = 1. In cycle 2, wb prda = 10 on slot 3 → busy_resp = 00 in the same cycle, and busy_count = 0 in cycle 3.
- Same bundle: slot0 writes prda = 20 and slot2 reads prsa[1] = 20 while busy[20] = 0 and wb 20 is asserted → busy_resp[2] = 10. After fire, busy[20] = 1; the set wins over the clear.
- Slot0 writes prda = 0, then slot1 reads prsa = {0, 0} → busy_resp = 00, and busy_count is unchanged.
- Set regs 3, 4 and 5 (busy_count = 3), then assert redir together with a fire of prda = 7 → at the next cycle all four registers read 0 and busy_count = 0.
- ren_valid = 1111 with ren_fire = 0011, and slots 2 and 3 writing prda 30 and 31 → busy[30] and busy[31] stay 0. Slot 3 reading 30 in that cycle still sees busy_resp = 01.
